// File: rtl/fog_demod_integrator.sv
`timescale 1ns/1ps
// Square-wave demodulator with integrate-and-dump over M modulation periods.
// Emits one saturated 32-bit result per window with a one-cycle update strobe.
module fog_demod_integrator #(
  parameter int ADC_WIDTH = 14,
  parameter int ACC_WIDTH = 40
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_en,
  input  logic                        i_mod_phase,
  input  logic                        i_adc_valid,
  input  logic signed [ADC_WIDTH-1:0] i_adc_data,
  input  logic [7:0]                  i_ignore,
  input  logic [7:0]                  i_period_sel,
  output logic signed [31:0]          o_data,
  output logic                        o_update_strobe,
  output logic                        o_sat
);

  typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;

  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  state_t                      state;
  logic                        phase_q;
  logic signed [ACC_WIDTH-1:0] acc;
  logic                        acc_clamped;
  logic [7:0]                  skip_cnt;
  logic [7:0]                  period_cnt;
  logic [7:0]                  m_sel;

  logic                        rise, ph_edge, start, dump, restart, take, ovf, res_ovf;
  logic [7:0]                  skip_eff, skip_next;
  logic signed [ACC_WIDTH-1:0] acc_base, acc_next;
  logic signed [ACC_WIDTH:0]   samp_x, base_x, sum;
  logic [ACC_WIDTH-32:0]       upper;
  logic [31:0]                 result;
  logic                        clamp_next;

  always_comb begin
    rise     = i_mod_phase & ~phase_q;
    ph_edge  = i_mod_phase ^ phase_q;
    start    = (state == SYNC) & rise;
    dump     = (state == RUN) & rise & (period_cnt == m_sel);
    restart  = start | dump;
    // An edge cycle is the first cycle of the new half: its sample sees the fresh skip count.
    skip_eff = ph_edge ? i_ignore : skip_cnt;
    take     = i_adc_valid & (skip_eff == '0);
    skip_next = (i_adc_valid && skip_eff != '0) ? skip_eff - 8'd1 : skip_eff;

    acc_base = restart ? '0 : acc;
    samp_x   = {{(ACC_WIDTH+1-ADC_WIDTH){i_adc_data[ADC_WIDTH-1]}}, i_adc_data};
    base_x   = {acc_base[ACC_WIDTH-1], acc_base};
    sum      = i_mod_phase ? base_x + samp_x : base_x - samp_x;
    ovf      = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
    if (!ovf)
      acc_next = sum[ACC_WIDTH-1:0];
    else if (sum[ACC_WIDTH])
      acc_next = ACC_MIN;
    else
      acc_next = ACC_MAX;
    if (!take)
      acc_next = acc_base;
    clamp_next = (~restart & acc_clamped) | (take & ovf);

    // Result saturates when bits above 31 are not a pure sign extension.
    upper   = acc[ACC_WIDTH-1:31];
    res_ovf = ~((&upper) | ~(|upper));
    if (!res_ovf)
      result = acc[31:0];
    else if (acc[ACC_WIDTH-1])
      result = 32'h8000_0000;
    else
      result = 32'h7FFF_FFFF;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state           <= IDLE;
      phase_q         <= 1'b0;
      acc             <= '0;
      acc_clamped     <= 1'b0;
      skip_cnt        <= '0;
      period_cnt      <= '0;
      m_sel           <= '0;
      o_data          <= '0;
      o_update_strobe <= 1'b0;
      o_sat           <= 1'b0;
    end else begin
      phase_q         <= i_mod_phase;
      o_update_strobe <= 1'b0;
      if (!i_en) begin
        state       <= IDLE;
        acc         <= '0;
        acc_clamped <= 1'b0;
        skip_cnt    <= '0;
        period_cnt  <= '0;
      end else begin
        case (state)
          IDLE: state <= SYNC;
          SYNC: begin
            if (rise) begin
              state       <= RUN;
              m_sel       <= i_period_sel;
              period_cnt  <= '0;
              acc         <= acc_next;
              acc_clamped <= clamp_next;
              skip_cnt    <= skip_next;
            end
          end
          RUN: begin
            acc         <= acc_next;
            acc_clamped <= clamp_next;
            skip_cnt    <= skip_next;
            if (dump) begin
              o_data          <= result;
              o_sat           <= res_ovf | acc_clamped;
              o_update_strobe <= 1'b1;
              period_cnt      <= '0;
              m_sel           <= i_period_sel;
            end else if (rise) begin
              period_cnt <= period_cnt + 8'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
